lcd_scan_gen: RTL and testbench

Parametrised successor to the fixed 160x144 DMG LCD scan controller. It generates the LCD's pixel clock, line/frame sync, latch and polarity (alternation) strobes from a single clock. It requests pixels from the dual-port VRAM (registered read, 1-cycle latency) and quantises 2- or 4-bit pixels to the panel's 2-bit drive. 4-bit pixels use frame-rate control (FRC) temporal greyscale. It adds selectable alternation mode, an enable with clean frame-boundary stop, and a frame_start pulse for VRAM write arbitration.

---
 rtl/lcd_scan_gen_pkg.sv | 34 +++
 rtl/lcd_scan_gen_if.sv | 35 +++
 rtl/lcd_scan_gen_timing.sv | 106 ++++++++++
 rtl/lcd_scan_gen.sv | 116 +++++++++++
 tb/tb_lcd_scan_gen.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/lcd_scan_gen_pkg.sv
// Shared types, default geometry and the FRC quantiser for the LCD scan generator.
package lcd_scan_pkg;

    // Scan controller states
    typedef logic [0:0] state_t;
    localparam state_t StIdle = 1'b0;
    localparam state_t StScan = 1'b1;

    // Default panel geometry (DMG 160x144)
    localparam int unsigned H_ACTIVE_DEF = 160;
    localparam int unsigned H_BLANK_DEF  = 4;
    localparam int unsigned V_ACTIVE_DEF = 144;
    localparam int unsigned V_BLANK_DEF  = 10;
    localparam int unsigned PIX_DIV_DEF  = 2;
    localparam int unsigned PIX_BITS_DEF = 2;

    // Counter ceiling width that never collapses to zero bits
    function automatic int unsigned clog2w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_BLANK_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_BLANK_DEF;
    localparam int unsigned XW      = clog2w(H_ACTIVE_DEF);
    localparam int unsigned YW      = clog2w(V_ACTIVE_DEF);

    // Temporal greyscale: the low bits add one drive level in that many of every four phases
    function automatic logic [1:0] frc_level(input logic [3:0] pix, input logic [1:0] phase);
        logic [2:0] sum;
        sum = {1'b0, pix[3:2]} + {2'b00, (pix[1:0] > phase)};
        return (sum > 3'd3) ? 2'd3 : sum[1:0];
    endfunction

endpackage

// File: rtl/lcd_scan_gen_if.sv
// VRAM request / panel drive bundle of the LCD scan generator.
interface lcd_scan_gen_if #(
    parameter int unsigned PIX_BITS = 2,
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 8
);
    logic                en;
    logic                alt_mode;
    logic [PIX_BITS-1:0] data_in;
    logic [XW-1:0]       xpos_out;
    logic [YW-1:0]       ypos_out;
    logic                lcd_clk;
    logic                d0;
    logic                d1;
    logic                hsync;
    logic                vsync;
    logic                datal;
    logic                altsig;
    logic                control;
    logic                frame_start;

    // Scan generator side
    modport master (
        input  en, alt_mode, data_in,
        output xpos_out, ypos_out, lcd_clk, d0, d1, hsync, vsync, datal, altsig, control,
               frame_start
    );

    // System / VRAM / panel side
    modport slave (
        output en, alt_mode, data_in,
        input  xpos_out, ypos_out, lcd_clk, d0, d1, hsync, vsync, datal, altsig, control,
               frame_start
    );
endinterface

// File: rtl/lcd_scan_gen_timing.sv
// Pixel divider, line/frame counters and IDLE/SCAN control for the LCD scan generator.
module lcd_scan_timing
    import lcd_scan_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_BLANK  = H_BLANK_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_BLANK  = V_BLANK_DEF,
    parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
    localparam int unsigned DW = clog2w(PIX_DIV),
    localparam int unsigned HW = clog2w(H_ACTIVE + H_BLANK),
    localparam int unsigned VW = clog2w(V_ACTIVE + V_BLANK)
) (
    input  logic          clk_8m,
    input  logic          rst_n,
    input  logic          en_i,
    output logic          scan_o,
    output logic [DW-1:0] div_o,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic [1:0]    frame_o,
    output logic          h_wrap_o,
    output logic          v_wrap_o,
    output logic          act_o
);
    localparam logic [DW-1:0] DivLast = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] HLast   = HW'(H_ACTIVE + H_BLANK - 1);
    localparam logic [VW-1:0] VLast   = VW'(V_ACTIVE + V_BLANK - 1);
    localparam logic [HW-1:0] HAct    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] VAct    = VW'(V_ACTIVE);

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [1:0]      frame_q, frame_d;
    logic            div_wrap, h_wrap, v_wrap;

    // Wrap events cascade: pixel period -> line -> frame
    always_comb begin
        div_wrap = (state_q == StScan) && (div_q == DivLast);
        h_wrap   = div_wrap && (h_q == HLast);
        v_wrap   = h_wrap && (v_q == VLast);
    end

    // Next-state: counters run only in SCAN; stop is taken only at a frame wrap
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        unique case (state_q)
            StIdle: begin
                div_d   = '0;
                h_d     = '0;
                v_d     = '0;
                frame_d = '0;
                if (en_i) state_d = StScan;
            end
            StScan: begin
                div_d = div_wrap ? '0 : div_q + DW'(1);
                if (div_wrap) h_d = h_wrap ? '0 : h_q + HW'(1);
                if (h_wrap)   v_d = v_wrap ? '0 : v_q + VW'(1);
                if (v_wrap) begin
                    frame_d = frame_q + 2'd1;
                    if (!en_i) begin
                        state_d = StIdle;
                        frame_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    // Position and region flags for the strobe/data logic
    always_comb begin
        scan_o   = (state_q == StScan);
        div_o    = div_q;
        h_o      = h_q;
        v_o      = v_q;
        frame_o  = frame_q;
        h_wrap_o = h_wrap;
        v_wrap_o = v_wrap;
        act_o    = scan_o && (h_q < HAct) && (v_q < VAct);
    end

endmodule

// File: rtl/lcd_scan_gen.sv
// LCD scan generator: panel strobes, polarity alternation and pixel quantisation.
module lcd_scan_gen
    import lcd_scan_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_BLANK  = H_BLANK_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_BLANK  = V_BLANK_DEF,
    parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
    parameter int unsigned PIX_BITS = PIX_BITS_DEF
) (
    input logic            clk_8m,
    input logic            rst_n,
    lcd_scan_gen_if.master bus
);
    localparam int unsigned DW    = clog2w(PIX_DIV);
    localparam int unsigned HW    = clog2w(H_ACTIVE + H_BLANK);
    localparam int unsigned VW    = clog2w(V_ACTIVE + V_BLANK);
    localparam int unsigned XBits = clog2w(H_ACTIVE);
    localparam int unsigned YBits = clog2w(V_ACTIVE);

    localparam logic [DW-1:0] DivOne  = DW'(1);
    localparam logic [DW-1:0] DivHalf = DW'(PIX_DIV / 2);
    localparam logic [HW-1:0] HSync   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HLatch  = HW'(H_ACTIVE + 1);
    localparam logic [VW-1:0] VAct    = VW'(V_ACTIVE);

    logic          scan, act, h_wrap, v_wrap;
    logic [DW-1:0] div;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [1:0]    frame;
    logic [1:0]    phase, lvl, pix;
    logic [1:0]    hold_q, hold_d;
    logic          alt_q, alt_d, mode_q, mode_d;

    lcd_scan_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK),
        .PIX_DIV  (PIX_DIV)
    ) u_timing (
        .clk_8m   (clk_8m),
        .rst_n    (rst_n),
        .en_i     (bus.en),
        .scan_o   (scan),
        .div_o    (div),
        .h_o      (h),
        .v_o      (v),
        .frame_o  (frame),
        .h_wrap_o (h_wrap),
        .v_wrap_o (v_wrap),
        .act_o    (act)
    );

    // FRC phase spreads the dither spatially as well as over frames
    assign phase = frame + 2'(h) + 2'(v);

    if (PIX_BITS == 4) begin : g_frc
        assign lvl = frc_level(bus.data_in, phase);
    end else begin : g_direct
        assign lvl = bus.data_in;
    end

    // Keep the sampled level for the rest of the pixel period; clear outside the active area
    always_comb begin
        hold_d = hold_q;
        if (!act)              hold_d = '0;
        else if (div == DivOne) hold_d = lvl;
    end

    // Polarity toggles per frame or per line; mode is only picked up at a frame boundary
    always_comb begin
        alt_d  = alt_q;
        mode_d = mode_q;
        if (!scan) begin
            alt_d  = 1'b0;
            mode_d = bus.alt_mode;
        end else begin
            if (mode_q ? h_wrap : v_wrap) alt_d = ~alt_q;
            if (v_wrap) mode_d = bus.alt_mode;
        end
    end

    // Data hold and alternation registers
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            alt_q  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            alt_q  <= alt_d;
            mode_q <= mode_d;
        end
    end

    // Outputs decode straight from the registered counters so reset clears them at once
    always_comb begin
        pix = '0;
        if (act) pix = (div == DivOne) ? lvl : hold_q;
        bus.xpos_out    = act ? XBits'(h) : '0;
        bus.ypos_out    = act ? YBits'(v) : '0;
        bus.d0          = pix[0];
        bus.d1          = pix[1];
        bus.lcd_clk     = act && (div >= DivHalf);
        bus.hsync       = scan && (h == HSync);
        bus.datal       = scan && (h == HLatch) && (v < VAct);
        bus.vsync       = scan && (v == '0);
        bus.frame_start = scan && (h == '0) && (v == '0) && (div == '0);
        bus.altsig      = scan && alt_q;
        bus.control     = scan;
    end

endmodule

// File: tb/tb_lcd_scan_gen.sv
// Directed bench for lcd_scan_gen on a 4x3 panel: timing, data path, FRC, alternation, stop/reset.
module tb_lcd_scan_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_scan_gen_if #(.PIX_BITS(2), .XW(2), .YW(2)) b2 ();
    lcd_scan_gen_if #(.PIX_BITS(4), .XW(2), .YW(2)) b4 ();

    lcd_scan_gen #(
        .H_ACTIVE (4), .H_BLANK (3), .V_ACTIVE (3), .V_BLANK (1), .PIX_DIV (2), .PIX_BITS (2)
    ) dut2 (
        .clk_8m (clk),
        .rst_n  (rst_n),
        .bus    (b2)
    );

    lcd_scan_gen #(
        .H_ACTIVE (4), .H_BLANK (3), .V_ACTIVE (3), .V_BLANK (1), .PIX_DIV (2), .PIX_BITS (4)
    ) dut4 (
        .clk_8m (clk),
        .rst_n  (rst_n),
        .bus    (b4)
    );

    // VRAM model: registered read returning x^y
    always @(posedge clk) b2.data_in <= b2.xpos_out ^ b2.ypos_out;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    int          pix_exp [4] = '{1, 0, 3, 2};
    int          frc_exp [8] = '{2, 2, 1, 1, 3, 3, 3, 3};
    int          e_hs, e_dl, e_vs, e_fs, e_lc, e_ctl, e_pos, e_d2, e_alt;
    int          f, r, ln, p, h, dv;
    logic        run, act, x_hs, x_dl, x_vs, x_fs, x_lc, x_alt;
    logic [12:0] idle2, idle4;
    logic        found;

    initial begin
        e_hs = 0; e_dl = 0; e_vs = 0; e_fs = 0; e_lc = 0; e_ctl = 0; e_pos = 0; e_d2 = 0;
        e_alt = 0;
        rst_n = 1'b0;
        b2.en = 1'b0; b4.en = 1'b0;
        b2.alt_mode = 1'b0; b4.alt_mode = 1'b0;
        b4.data_in = 4'b0110;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with en low: nothing may move
        idle2 = '0; idle4 = '0;
        repeat (100) begin
            @(negedge clk);
            idle2 |= {b2.xpos_out, b2.ypos_out, b2.lcd_clk, b2.d0, b2.d1, b2.hsync, b2.vsync,
                      b2.datal, b2.altsig, b2.control, b2.frame_start};
            idle4 |= {b4.xpos_out, b4.ypos_out, b4.lcd_clk, b4.d0, b4.d1, b4.hsync, b4.vsync,
                      b4.datal, b4.altsig, b4.control, b4.frame_start};
        end
        check("idle_outputs_pb2", 32'(idle2), 32'd0);
        check("idle_outputs_pb4", 32'(idle4), 32'd0);

        b2.en = 1'b1; b4.en = 1'b1;
        @(negedge clk);

        // c counts clk_8m cycles from the first SCAN cycle; 14 per line, 56 per frame
        for (int c = 0; c < 520; c++) begin
            run = (c < 504);
            f = c / 56; r = c % 56; ln = r / 14; p = r % 14; h = p / 2; dv = p % 2;
            act  = run && (h < 4) && (ln < 3);
            x_hs = run && (h == 4);
            x_dl = run && (h == 5) && (ln < 3);
            x_vs = run && (ln == 0);
            x_fs = run && (r == 0);
            x_lc = act && (dv == 1);
            if (!run)         x_alt = 1'b0;
            else if (c < 280) x_alt = (f % 2) == 1;
            else              x_alt = (((c - 280) / 14) % 2) == 0;

            if (b2.hsync !== x_hs)       e_hs++;
            if (b2.datal !== x_dl)       e_dl++;
            if (b2.vsync !== x_vs)       e_vs++;
            if (b2.frame_start !== x_fs) e_fs++;
            if (b2.lcd_clk !== x_lc)     e_lc++;
            if (b2.control !== run)      e_ctl++;
            if (b2.altsig !== x_alt)     e_alt++;
            if (b2.xpos_out !== (act ? 2'(h) : 2'd0)) e_pos++;
            if (b2.ypos_out !== (act ? 2'(ln) : 2'd0)) e_pos++;
            if (!act) begin
                if ({b2.d1, b2.d0} !== 2'd0) e_d2++;
            end else if (dv == 1) begin
                if ({b2.d1, b2.d0} !== 2'(h ^ ln)) e_d2++;
            end

            if (c < 56 && ln == 1 && dv == 1 && h < 4)
                check($sformatf("pix_line1_x%0d", h), 32'({b2.d1, b2.d0}), 32'(pix_exp[h]));
            if (c < 448 && r == 1)
                check($sformatf("frc_pix00_frame%0d", f), 32'({b4.d1, b4.d0}), 32'(frc_exp[f]));
            if (c == 503) check("control_last_cycle", 32'(b2.control), 32'd1);
            if (c == 504) check("control_after_stop", 32'(b2.control), 32'd0);

            if (c == 200) b4.data_in = 4'hF;
            if (c == 244) begin b2.alt_mode = 1'b1; b4.alt_mode = 1'b1; end
            if (c == 462) begin b2.en = 1'b0; b4.en = 1'b0; end
            @(negedge clk);
        end

        check("hsync_pattern", 32'(e_hs), 32'd0);
        check("datal_pattern", 32'(e_dl), 32'd0);
        check("vsync_pattern", 32'(e_vs), 32'd0);
        check("frame_start_pattern", 32'(e_fs), 32'd0);
        check("lcd_clk_pattern", 32'(e_lc), 32'd0);
        check("control_pattern", 32'(e_ctl), 32'd0);
        check("xy_request_pattern", 32'(e_pos), 32'd0);
        check("data_pb2_pattern", 32'(e_d2), 32'd0);
        check("altsig_pattern", 32'(e_alt), 32'd0);

        // Restart, then reset in the middle of an hsync pulse
        b2.en = 1'b1; b4.en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (b2.hsync === 1'b1) found = 1'b1;
        end
        check("hsync_seen_before_reset", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("hsync_async_reset", 32'(b2.hsync), 32'd0);
        check("control_async_reset", 32'(b2.control), 32'd0);
        #20;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
